// File: rtl/regfile_seq_pkg.sv
// Shared definitions for the regfile_seq sequencer: default widths, opcodes, FSM states.
// The optional immediate-operand feature is enabled with REGFILE_SEQ_IMM_EN.
package regfile_seq_pkg;

    localparam int unsigned DATA_W_DFLT = 16;
    localparam int unsigned ADDR_W_DFLT = 5;
    localparam int unsigned OPC_W_DFLT  = 3;

    localparam logic [OPC_W_DFLT-1:0] OpAdd = 3'd0;
    localparam logic [OPC_W_DFLT-1:0] OpSub = 3'd1;
    localparam logic [OPC_W_DFLT-1:0] OpAnd = 3'd2;
    localparam logic [OPC_W_DFLT-1:0] OpOr  = 3'd3;
    localparam logic [OPC_W_DFLT-1:0] OpXor = 3'd4;
    localparam logic [OPC_W_DFLT-1:0] OpSll = 3'd5;
    localparam logic [OPC_W_DFLT-1:0] OpSrl = 3'd6;
    localparam logic [OPC_W_DFLT-1:0] OpSra = 3'd7;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StExec,
        StWb
    } state_e;

    // Shift results leave through the shift-write port instead of the ALU write port.
    function automatic logic is_shift(input logic [OPC_W_DFLT-1:0] op);
        return (op == OpSll) || (op == OpSrl) || (op == OpSra);
    endfunction

endpackage

// File: rtl/seq_alu.sv
// Combinational datapath for regfile_seq: op/A/B to result plus ADD carry / SUB borrow.
module seq_alu
    import regfile_seq_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DFLT,
    parameter int unsigned OPC_W  = OPC_W_DFLT
) (
    input  logic [OPC_W-1:0]  i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_result,
    output logic              o_carry
);

    localparam int unsigned SHW = $clog2(DATA_W);

    logic [DATA_W:0] w_sum;
    logic [DATA_W:0] w_diff;
    logic [SHW-1:0]  w_shamt;

    assign w_sum   = {1'b0, i_a} + {1'b0, i_b};
    // Top bit of the widened difference is the unsigned borrow (A < B).
    assign w_diff  = {1'b0, i_a} - {1'b0, i_b};
    assign w_shamt = i_b[SHW-1:0];

    always_comb begin
        o_result = '0;
        o_carry  = 1'b0;
        unique case (i_op)
            OpAdd: begin
                o_result = w_sum[DATA_W-1:0];
                o_carry  = w_sum[DATA_W];
            end
            OpSub: begin
                o_result = w_diff[DATA_W-1:0];
                o_carry  = w_diff[DATA_W];
            end
            OpAnd:   o_result = i_a & i_b;
            OpOr:    o_result = i_a | i_b;
            OpXor:   o_result = i_a ^ i_b;
            OpSll:   o_result = i_a << w_shamt;
            OpSrl:   o_result = i_a >> w_shamt;
            OpSra:   o_result = DATA_W'($signed(i_a) >>> w_shamt);
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/regfile_seq.sv
// Read/execute/writeback sequencer driving a 32x16 register file, one instruction per 4 cycles.
// Define REGFILE_SEQ_IMM_EN to add the imm_sel/imm immediate operand ports.
module regfile_seq
    import regfile_seq_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DFLT,
    parameter int unsigned ADDR_W = ADDR_W_DFLT,
    parameter int unsigned OPC_W  = OPC_W_DFLT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [OPC_W-1:0]  op,
    input  logic [ADDR_W-1:0] rd,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
`ifdef REGFILE_SEQ_IMM_EN
    input  logic              imm_sel,
    input  logic [DATA_W-1:0] imm,
`endif
    output logic              readA,
    output logic [ADDR_W-1:0] rdAddrA,
    input  logic [DATA_W-1:0] rdDataA,
    output logic              readB,
    output logic [ADDR_W-1:0] rdAddrB,
    input  logic [DATA_W-1:0] rdDataB,
    output logic              write,
    output logic              wshift,
    output logic [ADDR_W-1:0] wrAddr,
    output logic [DATA_W-1:0] wrData,
    output logic [DATA_W-1:0] shData,
    output logic              done,
    output logic              zero,
    output logic              carry
);

    state_e             r_state;
    state_e             w_state_next;
    logic [OPC_W-1:0]   r_op;
    logic [ADDR_W-1:0]  r_rd;
    logic [ADDR_W-1:0]  r_rd_addr_a;
    logic [ADDR_W-1:0]  r_rd_addr_b;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [DATA_W-1:0]  r_wr_data;
    logic [DATA_W-1:0]  r_sh_data;
    logic               r_zero;
    logic               r_carry;
    logic [DATA_W-1:0]  w_op_b;
    logic               w_read_b_en;
    logic [DATA_W-1:0]  w_result;
    logic               w_alu_carry;
    logic               w_accept;

    assign w_accept = (r_state == StIdle) && instr_valid;

`ifdef REGFILE_SEQ_IMM_EN
    logic               r_imm_sel;
    logic [DATA_W-1:0]  r_imm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_imm_sel <= 1'b0;
            r_imm     <= '0;
        end else if (w_accept) begin
            r_imm_sel <= imm_sel;
            r_imm     <= imm;
        end
    end

    assign w_op_b      = r_imm_sel ? r_imm : rdDataB;
    assign w_read_b_en = !r_imm_sel;
`else
    assign w_op_b      = rdDataB;
    assign w_read_b_en = 1'b1;
`endif

    seq_alu #(
        .DATA_W (DATA_W),
        .OPC_W  (OPC_W)
    ) u_alu (
        .i_op     (r_op),
        .i_a      (rdDataA),
        .i_b      (w_op_b),
        .o_result (w_result),
        .o_carry  (w_alu_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_op        <= '0;
            r_rd        <= '0;
            r_rd_addr_a <= '0;
            r_rd_addr_b <= '0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_sh_data   <= '0;
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_op        <= op;
                r_rd        <= rd;
                r_rd_addr_a <= rs1;
                r_rd_addr_b <= rs2;
            end
            // Read data registered by the file during READ is valid here.
            if (r_state == StExec) begin
                r_wr_addr <= r_rd;
                if (is_shift(r_op)) begin
                    r_sh_data <= w_result;
                end else begin
                    r_wr_data <= w_result;
                end
                r_zero <= (w_result == '0);
                if ((r_op == OpAdd) || (r_op == OpSub)) begin
                    r_carry <= w_alu_carry;
                end
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        instr_ready  = 1'b0;
        readA        = 1'b0;
        readB        = 1'b0;
        write        = 1'b0;
        wshift       = 1'b0;
        done         = 1'b0;
        unique case (r_state)
            StIdle: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    w_state_next = StRead;
                end
            end
            StRead: begin
                readA        = 1'b1;
                readB        = w_read_b_en;
                w_state_next = StExec;
            end
            StExec: begin
                w_state_next = StWb;
            end
            StWb: begin
                write        = !is_shift(r_op);
                wshift       = is_shift(r_op);
                done         = 1'b1;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    assign rdAddrA = r_rd_addr_a;
    assign rdAddrB = r_rd_addr_b;
    assign wrAddr  = r_wr_addr;
    assign wrData  = r_wr_data;
    assign shData  = r_sh_data;
    assign zero    = r_zero;
    assign carry   = r_carry;

endmodule

// File: tb/tb_regfile_seq.sv
// Directed bench for regfile_seq with a behavioural 32x16 register file behind it.
// Immediate-operand steps are compiled only when REGFILE_SEQ_IMM_EN is defined.
module tb_regfile_seq;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        readA;
    logic [4:0]  rdAddrA;
    logic [15:0] rdDataA;
    logic        readB;
    logic [4:0]  rdAddrB;
    logic [15:0] rdDataB;
    logic        write;
    logic        wshift;
    logic [4:0]  wrAddr;
    logic [15:0] wrData;
    logic [15:0] shData;
    logic        done;
    logic        zero;
    logic        carry;
`ifdef REGFILE_SEQ_IMM_EN
    logic        imm_sel;
    logic [15:0] imm;
`endif

    logic [15:0] mem [32];
    logic        pl_en;
    logic [4:0]  pl_addr;
    logic [15:0] pl_data;
    int          wr_count;
    int          readb_count;
    int          errors;
    int          checks;
    int          saved;

    regfile_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .op          (op),
        .rd          (rd),
        .rs1         (rs1),
        .rs2         (rs2),
`ifdef REGFILE_SEQ_IMM_EN
        .imm_sel     (imm_sel),
        .imm         (imm),
`endif
        .readA       (readA),
        .rdAddrA     (rdAddrA),
        .rdDataA     (rdDataA),
        .readB       (readB),
        .rdAddrB     (rdAddrB),
        .rdDataB     (rdDataB),
        .write       (write),
        .wshift      (wshift),
        .wrAddr      (wrAddr),
        .wrData      (wrData),
        .shData      (shData),
        .done        (done),
        .zero        (zero),
        .carry       (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: registered reads, writes on either strobe, bench preload port.
    always @(posedge clk) begin
        if (readA) rdDataA <= mem[rdAddrA];
        if (readB) rdDataB <= mem[rdAddrB];
        if (write) mem[wrAddr] <= wrData;
        if (wshift) mem[wrAddr] <= shData;
        if (pl_en) mem[pl_addr] <= pl_data;
        if (write || wshift) wr_count <= wr_count + 1;
        if (readB) readb_count <= readb_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [4:0] a, input logic [15:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        step();
        pl_en   = 1'b0;
    endtask

    // Offers one instruction and returns #1 after the accepting edge (state READ).
    task automatic issue(input logic [2:0] o, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2);
        op          = o;
        rd          = d;
        rs1         = s1;
        rs2         = s2;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        wr_count    = 0;
        readb_count = 0;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        op          = '0;
        rd          = '0;
        rs1         = '0;
        rs2         = '0;
        rdDataA     = '0;
        rdDataB     = '0;
        pl_en       = 1'b0;
        pl_addr     = '0;
        pl_data     = '0;
`ifdef REGFILE_SEQ_IMM_EN
        imm_sel     = 1'b0;
        imm         = '0;
`endif
        for (int i = 0; i < 32; i++) mem[i] = '0;

        #1;
        check("reset_ready", instr_ready, 1);
        check("reset_strobes", {readA, readB, write, wshift, done}, 0);
        check("reset_flags", {zero, carry}, 0);
        check("reset_wraddr", wrAddr, 0);
        check("reset_wrdata", wrData, 0);
        step();
        step();
        rst_n = 1'b1;

        // ADD 0x7FFF + 0x0001
        preload(5'd1, 16'h7FFF);
        preload(5'd2, 16'h0001);
        issue(3'd0, 5'd3, 5'd1, 5'd2);
        check("add_read_strobes", {readA, readB}, 2'b11);
        check("add_read_addrs", {rdAddrA, rdAddrB}, {5'd1, 5'd2});
        check("add_ready_busy", instr_ready, 0);
        step();
        check("add_exec_no_wb", {write, wshift, done}, 0);
        step();
        check("add_wb_strobes", {write, wshift, done}, 3'b101);
        check("add_wraddr", wrAddr, 3);
        check("add_wrdata", wrData, 16'h8000);
        check("add_flags", {zero, carry}, 0);
        step();
        check("add_done_pulse", {done, write}, 0);
        check("add_ready_idle", instr_ready, 1);
        check("add_mem", mem[3], 16'h8000);

        // SUB 1 - 2 borrows
        preload(5'd1, 16'h0001);
        preload(5'd2, 16'h0002);
        issue(3'd1, 5'd4, 5'd1, 5'd2);
        step();
        step();
        check("sub_wrdata", wrData, 16'hFFFF);
        check("sub_flags", {zero, carry}, 2'b01);
        step();
        check("sub_mem", mem[4], 16'hFFFF);

        // Reset during EXEC discards the instruction
        preload(5'd20, 16'h1234);
        issue(3'd0, 5'd20, 5'd1, 5'd2);
        step();
        saved = wr_count;
        #2 rst_n = 1'b0;
        #1;
        check("rst_ready", instr_ready, 1);
        check("rst_flags", {zero, carry}, 0);
        check("rst_strobes", {write, wshift, done}, 0);
        step();
        rst_n = 1'b1;
        step();
        step();
        step();
        check("rst_no_writeback", wr_count, saved);
        check("rst_mem_kept", mem[20], 16'h1234);
        check("rst_ready_after", instr_ready, 1);

        // SUB r4 - r4 gives zero, clears carry
        issue(3'd1, 5'd11, 5'd4, 5'd4);
        step();
        step();
        check("subz_wrdata", wrData, 0);
        check("subz_flags", {zero, carry}, 2'b10);
        step();

        // Shifts of 0x8001 by 4
        preload(5'd5, 16'h8001);
        preload(5'd6, 16'h0004);
        issue(3'd7, 5'd7, 5'd5, 5'd6);
        step();
        step();
        check("sra_strobes", {write, wshift}, 2'b01);
        check("sra_wraddr", wrAddr, 7);
        check("sra_shdata", shData, 16'hF800);
        step();
        check("sra_mem", mem[7], 16'hF800);
        issue(3'd5, 5'd12, 5'd5, 5'd6);
        step();
        step();
        check("sll_shdata", shData, 16'h0010);
        step();
        check("sll_mem", mem[12], 16'h0010);
        issue(3'd6, 5'd13, 5'd5, 5'd6);
        step();
        step();
        check("srl_shdata", shData, 16'h0800);
        step();
        issue(3'd4, 5'd14, 5'd5, 5'd6);
        step();
        step();
        check("xor_strobes", {write, wshift}, 2'b10);
        check("xor_wrdata", wrData, 16'h8005);
        step();

        // Back-to-back with instr_valid held; second reads the freshly written r8
        preload(5'd8, 16'h5555);
        op          = 3'd0;
        rd          = 5'd8;
        rs1         = 5'd1;
        rs2         = 5'd2;
        instr_valid = 1'b1;
        step();
        op  = 3'd2;
        rd  = 5'd9;
        rs1 = 5'd8;
        rs2 = 5'd8;
        check("b2b_busy1", instr_ready, 0);
        step();
        check("b2b_busy2", instr_ready, 0);
        step();
        check("b2b_first_wraddr", wrAddr, 8);
        check("b2b_first_wrdata", wrData, 16'h0003);
        step();
        check("b2b_ready_4th", instr_ready, 1);
        step();
        instr_valid = 1'b0;
        check("b2b_second_accept", {instr_ready, readA, rdAddrA}, {1'b0, 1'b1, 5'd8});
        step();
        step();
        check("b2b_second_wb", {write, wrAddr, wrData}, {1'b1, 5'd9, 16'h0003});
        step();
        check("b2b_mem9", mem[9], 16'h0003);

`ifdef REGFILE_SEQ_IMM_EN
        saved   = readb_count;
        imm_sel = 1'b1;
        imm     = 16'h00FF;
        issue(3'd4, 5'd10, 5'd1, 5'd0);
        imm_sel = 1'b0;
        imm     = 16'hAAAA;
        check("imm_readb_low", {readA, readB}, 2'b10);
        step();
        step();
        check("imm_wrdata", wrData, 16'h00FE);
        step();
        check("imm_no_readb", readb_count, saved);
        check("imm_mem", mem[10], 16'h00FE);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_seq.md
Name: regfile_seq

Overview:
Single-issue read/execute/writeback sequencer that drives the 32x16 register file.
- Accepts one register-register instruction per handshake.
- Issues read strobes and addresses, consumes the registered read data one cycle later, computes the result, then writes it back.
- ALU results go through the write port; shift results go through the shift-write port.
- Sits directly upstream of the register file and is its only driver.

Parameters:
DATA_W, 16, operand/result width (must match register file)
ADDR_W, 5, register address width
OPC_W, 3, opcode width

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  instruction offered
instr_ready  out  1  sequencer can accept (high only in IDLE)
op  in  OPC_W  opcode, sampled on accept
rd  in  ADDR_W  destination register, sampled on accept
rs1  in  ADDR_W  source A register, sampled on accept
rs2  in  ADDR_W  source B register, sampled on accept
readA  out  1  register file read strobe A
rdAddrA  out  ADDR_W  read address A
rdDataA  in  DATA_W  registered read data A
readB  out  1  read strobe B
rdAddrB  out  ADDR_W  read address B
rdDataB  in  DATA_W  registered read data B
write  out  1  ALU-result write strobe
wshift  out  1  shift-result write strobe
wrAddr  out  ADDR_W  write address (shared by both write strobes)
wrData  out  DATA_W  ALU result
shData  out  DATA_W  shift result
done  out  1  one-cycle pulse, coincident with the writeback strobe
zero  out  1  last result == 0
carry  out  1  carry/borrow of last ADD/SUB

Behaviour:
- Reset (async, rst_n low): state=IDLE; instr_ready=1; all strobes=0, done=0, zero=0, carry=0; addresses/data=0. An in-flight instruction is discarded and no writeback occurs.
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA. Shift amount = B[3:0].
- FSM states: IDLE -> READ -> EXEC -> WB -> IDLE.
  - IDLE: instr_ready=1. On instr_valid, capture op/rd/rs1/rs2 and go to READ. Later changes to the inputs are ignored.
  - READ: readA=readB=1, rdAddrA=rs1, rdAddrB=rs2. Data is valid on the next cycle.
  - EXEC: compute from rdDataA/rdDataB into a result register. Update zero. Update carry for ADD (bit 16 of the 17-bit sum) and SUB (1 when A<B unsigned); other ops hold carry.
  - WB: for ops 0-4, write=1 with wrData=result. For ops 5-7, wshift=1 with shData=result. wrAddr=rd; done=1.
- Exactly one of write/wshift is high in WB, and neither is high outside WB.
- Latency: accept at edge N, read strobe at cycle N+1, writeback strobe at cycle N+3. Throughput is one instruction per 4 cycles.
- Strobes are low when unused; addresses hold their last values.
- Hazards: none. Writeback completes before the next read, so rd==rs of the next instruction returns the new value.
- Arithmetic wraps modulo 2^16. SRA replicates bit 15. Shift by 0 returns A unchanged.
- instr_valid is ignored outside IDLE, where instr_ready=0.

Optional Feature:
Macro REGFILE_SEQ_IMM_EN.
- Defined: adds ports imm_sel (in, 1) and imm (in, DATA_W), both sampled on accept. When imm_sel=1, operand B=imm and readB stays 0 in READ.
- Undefined: the ports are absent and B always comes from rdDataB.

Decomposition:
- Package regfile_seq_pkg: opcode localparams, FSM state enum (2-bit), DATA_W/ADDR_W defaults.
- Sub-module seq_alu: purely combinational op/A/B -> result, carry. The FSM and registers stay in the top.

Test Plan:
- Reset mid-EXEC (rst_n low for 1 cycle) -> no write/wshift occurs; instr_ready=1 immediately; zero=0, carry=0.
- Preload r1=0x7FFF, r2=0x0001; ADD rd=3 -> write=1, wrAddr=3, wrData=0x8000 at accept+3; carry=0, zero=0; done pulse of 1 cycle.
- r1=0x0001, r2=0x0002; SUB rd=4 -> wrData=0xFFFF, carry=1; follow with SUB r4-r4 -> rd 0x0000, zero=1, carry=0.
- r5=0x8001, r6=0x0004; SRA rd=7 -> wshift=1, write=0, shData=0xF800; SLL -> 0x0010; SRL -> 0x0800.
- Back-to-back: ADD r8=r1+r2, then AND r9=r8&r8 with instr_valid held high -> second accept exactly 4 cycles after the first; r9 equals the new r8.
- With REGFILE_SEQ_IMM_EN: XOR rd=10, rs1=r1, imm_sel=1, imm=0x00FF -> readB never asserted; wrData=r1^0x00FF.
